// File: rtl/fp16_dot_sequencer_if.sv
// fp16_dot_sequencer_if: operand stream, FMA issue/return and result signals of the dot-product sequencer.
interface fp16_dot_sequencer_if #(parameter int LEN_W = 16);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             fma_in_valid;
    logic [15:0]      fma_a;
    logic [15:0]      fma_b;
    logic [15:0]      fma_c;
    logic             fma_out_valid;
    logic [15:0]      fma_out;
    logic             res_valid;
    logic [15:0]      res_data;

    modport master (
        output start, len, in_valid, in_a, in_b, fma_out_valid, fma_out,
        input  busy, in_ready, fma_in_valid, fma_a, fma_b, fma_c, res_valid, res_data
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, fma_out_valid, fma_out,
        output busy, in_ready, fma_in_valid, fma_a, fma_b, fma_c, res_valid, res_data
    );
endinterface

// File: rtl/fp16_dot_sequencer.sv
// fp16_dot_sequencer: FP16 dot product over one shared FMA, interleaving FMA_LAT lane partial sums then reducing them.
module fp16_dot_sequencer #(
    parameter int FMA_LAT = 4,
    parameter int LEN_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    fp16_dot_sequencer_if.slave  s
);
    localparam int LW = FMA_LAT > 1 ? $clog2(FMA_LAT) : 1;
    localparam logic [2:0] IDLE = 3'd0, ACCUM = 3'd1, DRAIN = 3'd2, REDUCE = 3'd3, DONE = 3'd4;

    logic [2:0]                   state;
    logic [LEN_W-1:0]             len_q, issued, rk, used;
    logic [LW-1:0]                lp, rl, iss_lane;
    logic [15:0]                  psum [FMA_LAT];
    logic [15:0]                  res_q;
    logic [FMA_LAT-1:0]           pend, pend_nxt, tag_v;
    logic [FMA_LAT-1:0][LW-1:0]   tag_l;
    logic                         ret, hit, fire, red;

    assign ret      = s.fma_out_valid & tag_v[FMA_LAT-1];
    assign rl       = tag_l[FMA_LAT-1];
    assign hit      = ret && rl == lp;
    assign s.in_ready = state == ACCUM && issued < len_q && (!pend[lp] || hit);
    assign fire     = s.in_valid & s.in_ready;
    // Reduction ops accumulate into psum[0], so they travel the pipe tagged as lane 0.
    assign red      = state == REDUCE && !pend[0];
    assign iss_lane = fire ? lp : '0;
    assign used     = len_q < LEN_W'(FMA_LAT) ? len_q : LEN_W'(FMA_LAT);

    assign s.fma_in_valid = fire | red;
    assign s.fma_a    = fire ? s.in_a : red ? psum[rk[LW-1:0]] : 16'h0000;
    assign s.fma_b    = fire ? s.in_b : red ? 16'h3C00 : 16'h0000;
    assign s.fma_c    = fire ? (hit ? s.fma_out : psum[lp]) : red ? psum[0] : 16'h0000;
    assign s.busy     = state != IDLE;
    assign s.res_valid = state == DONE;
    assign s.res_data = s.res_valid ? psum[0] : res_q;

    always_comb begin
        pend_nxt = pend;
        if (ret) pend_nxt[rl] = 1'b0;
        if (fire | red) pend_nxt[iss_lane] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            len_q  <= '0;
            issued <= '0;
            rk     <= '0;
            lp     <= '0;
            pend   <= '0;
            tag_v  <= '0;
            tag_l  <= '0;
            psum   <= '{default: '0};
            res_q  <= '0;
        end else begin
            pend  <= pend_nxt;
            tag_v <= {tag_v[FMA_LAT-2:0], fire | red};
            tag_l <= {tag_l[FMA_LAT-2:0], iss_lane};
            if (ret && !(fire && hit)) psum[rl] <= s.fma_out;
            if (fire) begin
                issued <= issued + 1'b1;
                lp     <= lp == LW'(FMA_LAT - 1) ? '0 : lp + 1'b1;
            end
            if (red) rk <= rk + 1'b1;
            case (state)
                IDLE: if (s.start) begin
                    len_q  <= s.len;
                    issued <= '0;
                    lp     <= '0;
                    rk     <= LEN_W'(1);
                    psum   <= '{default: '0};
                    state  <= s.len == '0 ? DONE : ACCUM;
                end
                ACCUM:  if (issued == len_q) state <= DRAIN;
                DRAIN:  if (pend_nxt == '0) state <= used > LEN_W'(1) ? REDUCE : DONE;
                REDUCE: if (ret && rk == used) state <= DONE;
                DONE: begin
                    res_q <= psum[0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fp16_dot_sequencer.md
# fp16_dot_sequencer

Sequencer that computes one FP16 dot product, sum(a_k*b_k) for k = 0..len-1, by streaming operand pairs through a single shared FP16 fused multiply-add pipeline. The FMA has a fixed latency and no stall, so the block interleaves FMA_LAT independent partial sums, one per pipeline slot, to sustain one element per cycle. When all elements are in, it reduces the lanes through the same FMA using b = 1.0. It sits between an operand streamer, such as a TPU row feeder, and one FMA instance.

## Interface
- FMA_LAT, 4: cycles from fma_in_valid to the matching fma_out_valid; also the number of accumulation lanes.
- LEN_W, 16: width of the element count.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  begin a new dot product; sampled only in IDLE.
- len  in  LEN_W  element count, captured with start.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_a, in_b  in  16  FP16 operands.
- fma_in_valid  out  1  issue to the FMA.
- fma_a, fma_b, fma_c  out  16  FMA operands; the FMA computes a*b+c.
- fma_out_valid  in  1  FMA result valid.
- fma_out  in  16  FMA result.
- res_valid  out  1  one-cycle pulse; the result is ready.
- res_data  out  16  dot-product result; held until the next accepted start.

## Operation
- Reset values: state = IDLE, busy = 0, in_ready = 0, fma_in_valid = 0, fma_a/b/c = 0, res_valid = 0, res_data = 0.
- Reset also clears all psum, pending and tag state. FMA results that arrive after reset are ignored.
- Lane storage:
  - psum[0..FMA_LAT-1], 16 bits each, plus a pending bit per lane.
  - A tag shift register, FMA_LAT deep, holds {valid, lane} and is aligned with fma_out_valid.
- IDLE:
  - On start, capture len and reset the counters (issued = 0, lane pointer = 0).
  - len == 0: go to DONE with res_data = 16'h0000.
  - Otherwise go to ACCUM.
- ACCUM, element issue:
  - Target lane L = issued mod FMA_LAT.
  - in_ready = (issued < len) AND (pending[L] == 0 OR a result for lane L is returning this cycle).
  - On in_valid & in_ready: fma_a = in_a, fma_b = in_b, set pending[L], push tag L, increment issued.
  - fma_c = 16'h0000 for the first use of each lane.
  - Otherwise fma_c = psum[L]. If lane L's result is returning in the same cycle, fma_c = fma_out (combinational bypass).
- Result capture, in all states:
  - On fma_out_valid with a valid tag, write fma_out into psum[tag], unless the bypass consumed it in the same cycle.
  - Clear pending[tag], except when the same lane is re-issued in that cycle.
- Transitions:
  - ACCUM goes to DRAIN when issued == len.
  - DRAIN goes to REDUCE when no lane is pending.
- REDUCE:
  - used = min(len, FMA_LAT). Set acc = psum[0].
  - For k = 1..used-1, serially: issue fma_a = psum[k], fma_b = 16'h3C00, fma_c = acc. Wait for the result, then set acc = result.
  - Each op issues in the cycle after the previous capture.
  - Lanes with index >= used are skipped.
  - After the last capture (immediately if used == 1), go to DONE.
- DONE:
  - res_data = acc, res_valid = 1 for this cycle, then IDLE.
- start while busy is ignored.
- Input pairs presented while in_ready = 0 are not consumed.
- The block applies no special handling to Inf or subnormal values; the FMA's behaviour passes through.

## Timing
- start is sampled in cycle 0. ACCUM is entered in cycle 1, and in_ready can be high from cycle 1.
- With continuous in_valid, in_ready stays high, and element k is accepted in cycle 1+k (one element per cycle).
- A lane result issued in cycle t returns in cycle t+FMA_LAT. That is the same cycle lane L is re-issued, which is why the bypass is mandatory for full throughput.
- Latency from start to res_valid, with continuous input: N + FMA_LAT + 1 + (FMA_LAT+1)*(min(N,FMA_LAT)-1).
  - FMA_LAT = 4, N = 1: cycle 6.
  - FMA_LAT = 4, N >= 4: cycle N + 20.
  - len == 0: res_valid in cycle 1.
- An in_valid gap shifts completion by the gap length. The lane order is unchanged (lane = element index mod FMA_LAT).
- busy rises in the cycle after start and falls in the cycle after res_valid.
- rst = 0 in any cycle returns the block to IDLE at the next edge, whatever the state.

## Test plan
- len = 8, all pairs a = 16'h3C00, b = 16'h4000, continuous input -> in_ready never drops; res_data = 16'h4C00 (16.0); res_valid in cycle 28.
- len = 0 -> res_valid in cycle 1, res_data = 16'h0000, fma_in_valid never asserted.
- len = 3, pairs (1.0,1.0), (2.0,2.0), (-1.0,1.0) -> exactly 2 reduce ops, lane 3 never used; res_data = 16'h4400 (4.0); res_valid in cycle 3 + 4 + 1 + 10 = 18.
- len = 8 with in_valid low every other cycle -> no lane is issued while pending without a bypass; result = 16.0; lane sequence 0,1,2,3,0,... is maintained.
- start pulsed during ACCUM, and a new start in the same cycle as res_valid -> both ignored; res_data stable until the next start accepted in IDLE.
- rst = 0 for one cycle during DRAIN with FMA results still in flight -> all outputs return to reset values; late fma_out_valid does not alter psum; a following len = 4 run of 1.0 * 1.0 gives 16'h4400.
